clk_en_gen: RTL and testbench

Parametrised multi-channel clock-enable generator that runs in the single master clock domain behind the core PLL.
- Produces NUM_CH independent fractional-rate clock enables, e.g. CPU, sound and video pixel enables derived from 49.152 MHz.
- Gates all enables until the PLL lock indication has been stable for a programmable settle time.
- Generalises the fixed three-output PLL arrangement: runtime-programmable rates per channel, lock supervision and loss-of-lock reporting.

---
 rtl/clk_en_gen.sv | 120 ++++++++++++
 tb/tb_clk_en_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator gated by PLL lock supervision.
// Optional build macro CLKEN_PHASE_SYNC_EN adds a phase_sync input that realigns all channels.
module clk_en_gen #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  output logic [NUM_CH-1:0]       ce,
  output logic                    ready,
  output logic                    lock_lost
`ifdef CLKEN_PHASE_SYNC_EN
  , input  logic                  phase_sync
`endif
);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  localparam logic [15:0] CNT_LAST = 16'(LOCK_CYCLES - 1);

  state_t            state, state_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic              lost_nxt;
  logic              locked_meta, locked_s;
  logic              psync;
  logic              acc_run;
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [ACC_W:0]    sum [NUM_CH];

`ifdef CLKEN_PHASE_SYNC_EN
  assign psync = phase_sync;
`else
  assign psync = 1'b0;
`endif

  // pll_locked is asynchronous to clk_sys
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ready     <= (state_nxt == RUN);
      lock_lost <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lost_nxt  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (locked_s) state_nxt = SETTLE;
      end
      SETTLE: begin
        // any dropout restarts the full settle window
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          lost_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Adding only while staying in RUN makes the entry edge, exit edge and phase_sync all clear to zero
  assign acc_run = (state == RUN) && locked_s && !psync;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sum[k] = {1'b0, acc[k]} + {1'b0, inc[k*ACC_W +: ACC_W]};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n || !acc_run) begin
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      ce <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc[k] <= sum[k][ACC_W-1:0];
        ce[k]  <= sum[k][ACC_W];
      end
    end
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: directed bring-up, rate, glitch and lock-loss steps plus random rates,
// checked every cycle against a lock-history / cumulative-phase reference model.
module tb_clk_en_gen;

  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int LC  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pll = 1'b0;
  logic              ps = 1'b0;
  logic [NCH*AW-1:0] inc = '0;
  logic [NCH-1:0]    ce;
  logic              ready;
  logic              lost;

  int checks = 0;
  int errors = 0;

  // reference model state
  int                run_len = 0;
  bit                prev_pll = 1'b0;
  bit                r_exp = 1'b0;
  bit                lost_exp = 1'b0;
  bit [NCH-1:0]      ce_exp = '0;
  longint unsigned   ph [NCH];

  clk_en_gen #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LC)) dut (
    .clk_sys   (clk),
    .rst_n     (rst_n),
    .pll_locked(pll),
    .inc       (inc),
    .ce        (ce),
    .ready     (ready),
    .lock_lost (lost)
`ifdef CLKEN_PHASE_SYNC_EN
    , .phase_sync(ps)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model from the inputs the DUT sampled, then compare.
  // ready(t) is high when locked_s stayed high over the previous LC+1 edges;
  // locked_s after edge t equals pll_locked sampled at edge t-1.
  task automatic step();
    bit r_new;
    longint unsigned old;
    @(posedge clk);
    if (!rst_n) begin
      run_len  = 0;
      prev_pll = 1'b0;
      r_exp    = 1'b0;
      lost_exp = 1'b0;
      ce_exp   = '0;
      for (int k = 0; k < NCH; k++) ph[k] = 0;
    end else begin
      r_new    = (run_len >= LC + 1);
      run_len  = prev_pll ? run_len + 1 : 0;
      prev_pll = pll;
      lost_exp = r_exp && !r_new;
      for (int k = 0; k < NCH; k++) begin
        if (r_exp && r_new && !ps) begin
          old    = ph[k];
          ph[k]  = ph[k] + longint'(inc[k*AW +: AW]);
          ce_exp[k] = ((ph[k] >> AW) != (old >> AW));
        end else begin
          ph[k]     = 0;
          ce_exp[k] = 1'b0;
        end
      end
      r_exp = r_new;
    end
    #1;
    chk("ready", 32'(ready), 32'(r_exp));
    chk("lock_lost", 32'(lost), 32'(lost_exp));
    chk("ce", 32'(ce), 32'(ce_exp));
  endtask

  // Counts edges from the first one sampling the current inputs until ready rises.
  task automatic wait_ready(output int e_rdy);
    e_rdy = -1;
    for (int e = 1; e <= 200; e++) begin
      step();
      if (ready === 1'b1) begin
        e_rdy = e;
        break;
      end
    end
  endtask

  initial begin
    int e_rdy, cnt0, cnt1, cnt2, first0, first1;

    for (int k = 0; k < NCH; k++) ph[k] = 0;

    // reset and bring-up
    inc = {16'h0000, 16'h4000, 16'h8000};
    repeat (4) step();
    rst_n = 1'b1;
    repeat (3) step();
    pll = 1'b1;
    wait_ready(e_rdy);
    chk("bringup_ready_edge", 32'(e_rdy), 32'd19);

    // integer rates over 4096 cycles
    cnt0 = 0; cnt1 = 0; cnt2 = 0; first0 = 0; first1 = 0;
    for (int i = 1; i <= 4096; i++) begin
      step();
      if (ce[0]) begin cnt0++; if (first0 == 0) first0 = 19 + i; end
      if (ce[1]) begin cnt1++; if (first1 == 0) first1 = 19 + i; end
      if (ce[2]) cnt2++;
    end
    chk("ch0_first_edge", 32'(first0), 32'd21);
    chk("ch1_first_edge", 32'(first1), 32'd23);
    chk("ch0_count", 32'(cnt0), 32'd2048);
    chk("ch1_count", 32'(cnt1), 32'd1024);
    chk("ch2_count", 32'(cnt2), 32'd0);

    // reset mid-RUN, then fractional rate 0x5555 from a fresh accumulator
    rst_n = 1'b0;
    repeat (2) step();
    inc[15:0] = 16'h5555;
    rst_n = 1'b1;
    wait_ready(e_rdy);
    chk("rerst_ready_edge", 32'(e_rdy), 32'd19);
    cnt0 = 0;
    for (int i = 1; i <= 3 * 8192; i++) begin
      step();
      if (ce[0]) cnt0++;
      if (i == 3 * 4096) chk("frac_count_half", 32'(cnt0), 32'd4095);
    end
    chk("frac_count", 32'(cnt0), 32'd8191);

    // random increments changing mid-run
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) inc[$urandom_range(NCH-1)*AW +: AW] = 16'($urandom);
      step();
    end

    // settle glitch at count 10 restarts the full settle window
    rst_n = 1'b0;
    pll   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    pll = 1'b1;
    repeat (13) step();
    chk("glitch_settling_ready", 32'(ready), 32'd0);
    pll = 1'b0;
    step();
    pll = 1'b1;
    wait_ready(e_rdy);
    chk("glitch_ready_edge", 32'(e_rdy), 32'd19);

    // lock loss while in RUN, then re-lock
    inc = {16'h1234, 16'h4000, 16'h8000};
    repeat (10) step();
    pll = 1'b0;
    step();
    chk("loss_e1_ready", 32'(ready), 32'd1);
    step();
    chk("loss_e2_ready", 32'(ready), 32'd1);
    chk("loss_e2_lost", 32'(lost), 32'd0);
    step();
    chk("loss_e3_ready", 32'(ready), 32'd0);
    chk("loss_e3_lost", 32'(lost), 32'd1);
    chk("loss_e3_ce", 32'(ce), 32'd0);
    step();
    chk("loss_e4_lost", 32'(lost), 32'd0);
    repeat (5) step();
    pll = 1'b1;
    wait_ready(e_rdy);
    chk("relock_ready_edge", 32'(e_rdy), 32'd19);

`ifdef CLKEN_PHASE_SYNC_EN
    // phase_sync realigns channels mid-run
    inc = {16'h0000, 16'h2000, 16'h4000};
    repeat (37) step();
    ps = 1'b1;
    step();
    chk("psync_ce", 32'(ce), 32'd0);
    ps = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("psync_ch0", 32'(ce[0]), 32'((i % 4) == 0));
      chk("psync_ch1", 32'(ce[1]), 32'((i % 8) == 0));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
